filter_test_sequencer: RTL and testbench

//  Sequences one filter-under-test run. Streams N stimulus addresses to the test ROM
//  and enables the filter. Writes each filter result into the capture RAM at the address

---
 rtl/filter_test_sequencer_if.sv | 37 +++
 rtl/filter_test_sequencer.sv | 152 +++++++++++++++
 tb/tb_filter_test_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/filter_test_sequencer_if.sv
// Control and stream bus between the run controller (bench side) and the
// filter test sequencer. The sequencer drives the ROM/filter/RAM side signals.
interface filter_test_sequencer_if #(
    parameter int ADDR_W = 8
);
    // Run control from the bench-level controller
    logic              start;
    logic              abort;
    logic              loop_mode;
    logic [ADDR_W-1:0] num_samples;

    // ROM / filter / capture RAM side
    logic [ADDR_W-1:0] rom_addr;
    logic              filt_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic              trig;
    logic              busy;
    logic              done;

    // Sequencer FSM state, exported for observation
    logic [1:0]        state_dbg;

    // Handshake: start is a single-cycle request that is only acted on while the
    // sequencer is idle (busy=0 and done=0); it is never queued. abort is a level
    // sampled on every rising edge and wins over start. ram_wren qualifies ram_addr
    // for exactly one cycle per result; done is a one-cycle completion pulse.
    modport master (
        output start, abort, loop_mode, num_samples,
        input  rom_addr, filt_en, ram_addr, ram_wren, trig, busy, done, state_dbg
    );

    modport slave (
        input  start, abort, loop_mode, num_samples,
        output rom_addr, filt_en, ram_addr, ram_wren, trig, busy, done, state_dbg
    );
endinterface

// File: rtl/filter_test_sequencer.sv
// Sequences one filter-under-test run: issues N stimulus ROM addresses, keeps the
// filter enabled until its pipeline drains, and writes each result to the capture
// RAM at the same address, PIPE_LAT cycles after its stimulus was issued.
module filter_test_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,   // asynchronous, active low
    filter_test_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   n_last_q,    n_last_d;     // N-1; N=0 gives all-ones
    logic                loop_q,      loop_d;
    logic [ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
    logic                filt_en_q,   filt_en_d;
    logic                trig_q,      trig_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [PIPE_LAT-1:0] vpipe_q,     vpipe_d;      // bit 0 set during an issue cycle
    logic                ram_wren_q,  ram_wren_d;
    logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
    logic [ADDR_W-1:0]   write_cnt_q, write_cnt_d;

    logic                issue_d;                   // next cycle issues an address
    logic                flush;                     // abort taken this edge
    logic [PIPE_LAT:0]   vpipe_shift;

    // Next-state, address counters and write pipeline
    always_comb begin
        state_d     = state_q;
        n_last_d    = n_last_q;
        loop_d      = loop_q;
        rom_addr_d  = rom_addr_q;
        write_cnt_d = write_cnt_q;
        ram_addr_d  = ram_addr_q;
        issue_d     = 1'b0;
        flush       = 1'b0;

        case (state_q)
            S_IDLE: begin
                rom_addr_d = '0;
                if (bus.start && !bus.abort) begin
                    state_d     = S_ISSUE;
                    n_last_d    = bus.num_samples - ADDR_W'(1);
                    loop_d      = bus.loop_mode;
                    write_cnt_d = '0;
                    issue_d     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (rom_addr_q == n_last_q) begin
                    if (loop_q) begin
                        rom_addr_d = '0;
                        issue_d    = 1'b1;
                    end else begin
                        // rom_addr holds the last address while draining
                        state_d = S_DRAIN;
                    end
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    issue_d    = 1'b1;
                end
            end
            S_DRAIN: begin
                // The last result is being written this cycle
                if (ram_wren_q && (ram_addr_q == n_last_q)) begin
                    state_d    = S_DONE;
                    rom_addr_d = '0;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                rom_addr_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort && (state_q != S_IDLE)) begin
            flush      = 1'b1;
            state_d    = S_IDLE;
            issue_d    = 1'b0;
            rom_addr_d = '0;
        end

        // Valid shift register tracks in-flight samples; abort discards them
        vpipe_shift = {vpipe_q, issue_d};
        vpipe_d     = flush ? '0 : vpipe_shift[PIPE_LAT-1:0];
        ram_wren_d  = vpipe_q[PIPE_LAT-1] && !flush;

        if (ram_wren_d) begin
            ram_addr_d  = write_cnt_q;
            write_cnt_d = (write_cnt_q == n_last_q) ? '0 : write_cnt_q + ADDR_W'(1);
        end

        filt_en_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        busy_d    = filt_en_d;
        done_d    = (state_d == S_DONE);
        trig_d    = issue_d && (rom_addr_d == '0);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            n_last_q    <= '0;
            loop_q      <= 1'b0;
            rom_addr_q  <= '0;
            filt_en_q   <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vpipe_q     <= '0;
            ram_wren_q  <= 1'b0;
            ram_addr_q  <= '0;
            write_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            n_last_q    <= n_last_d;
            loop_q      <= loop_d;
            rom_addr_q  <= rom_addr_d;
            filt_en_q   <= filt_en_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vpipe_q     <= vpipe_d;
            ram_wren_q  <= ram_wren_d;
            ram_addr_q  <= ram_addr_d;
            write_cnt_q <= write_cnt_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.filt_en   = filt_en_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wren  = ram_wren_q;
    assign bus.trig      = trig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Bench for filter_test_sequencer: directed runs plus randomized runs, checked
// cycle by cycle against a timeline model of a run and a write-order scoreboard.
module tb_filter_test_sequencer;
    localparam int ADDR_W = 8;
    localparam int PL     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [ADDR_W-1:0] exp_q[$];   // issued addresses awaiting their RAM write

    filter_test_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    filter_test_sequencer #(.ADDR_W(ADDR_W), .PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs in cycle k of a run (start sampled at edge 0), from the run timeline
    task automatic model(input int k, input int n, input bit lp, input int ab,
                         output bit ef, output bit eb, output bit et, output bit ed,
                         output bit ew, output bit ei, output int er);
        bit live, drain;
        live  = !(ab > 0 && k > ab);
        if (lp) begin
            ei    = (k >= 1);
            drain = 1'b0;
            ed    = 1'b0;
            ew    = (k >= PL + 1);
        end else begin
            ei    = (k >= 1) && (k <= n);
            drain = (k > n) && (k <= n + PL);
            ed    = (k == n + PL + 1);
            ew    = (k >= PL + 1) && (k <= n + PL);
        end
        ei = ei && live;
        ed = ed && live;
        ew = ew && live;
        ef = ei || (drain && live);
        eb = ef;
        er = ei ? (k - 1) % n : n - 1;
        et = ei && ((k - 1) % n == 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, bus.rom_addr, 0);
        check({tag, "_filt_en"},  bus.filt_en,  0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_ram_wren"}, bus.ram_wren, 0);
        check({tag, "_trig"},     bus.trig,     0);
        check({tag, "_busy"},     bus.busy,     0);
        check({tag, "_done"},     bus.done,     0);
    endtask

    // Quiet cycles: nothing may be happening
    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            check("idle_filt_en", bus.filt_en,  0);
            check("idle_busy",    bus.busy,     0);
            check("idle_wren",    bus.ram_wren, 0);
            check("idle_done",    bus.done,     0);
        end
    endtask

    // One run: start in the next cycle, then compare kmax cycles against the model
    task automatic run(input int n, input bit lp, input int ab, input int kmax, input bit glitch);
        int ne, dones, exp_dones, er;
        bit ef, eb, et, ed, ew, ei;
        logic [ADDR_W-1:0] want;
        ne    = (n == 0) ? (1 << ADDR_W) : n;
        dones = 0;
        exp_q.delete();
        @(negedge clk);
        bus.start       = 1'b1;
        bus.abort       = 1'b0;
        bus.num_samples = ADDR_W'(n);
        bus.loop_mode   = lp;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            model(k, ne, lp, ab, ef, eb, et, ed, ew, ei, er);
            check("filt_en",  bus.filt_en,  ef);
            check("busy",     bus.busy,     eb);
            check("trig",     bus.trig,     et);
            check("done",     bus.done,     ed);
            check("ram_wren", bus.ram_wren, ew);
            if (ei) begin
                check("rom_addr", bus.rom_addr, er);
                exp_q.push_back(ADDR_W'(er));
            end else if (ef) begin
                check("rom_hold", bus.rom_addr, er);
            end
            if (bus.ram_wren) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", bus.ram_wren, 0);
                end else begin
                    want = exp_q.pop_front();
                    check("ram_addr", bus.ram_addr, want);
                end
            end
            if (bus.done) dones++;
            bus.abort = (k == ab);
            if (glitch && (eb || ed)) begin
                bus.start       = 1'($urandom_range(0, 1));
                bus.num_samples = ADDR_W'($urandom);
                bus.loop_mode   = 1'($urandom_range(0, 1));
            end
        end
        exp_dones = (!lp && (ab == 0 || ab >= ne + PL + 1) && kmax >= ne + PL + 1) ? 1 : 0;
        check("done_count", dones, exp_dones);
        if (exp_dones == 1) check("wr_pending", exp_q.size(), 0);
    endtask

    initial begin
        int n, ab, kmax;
        bit lp;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.loop_mode   = 1'b0;
        bus.num_samples = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        idle(2);

        // Basic run, then a back-to-back run with start pulses while busy / in DONE
        run(4, 1'b0, 0, 4 + PL + 1, 1'b0);
        run(5, 1'b0, 0, 5 + PL + 1, 1'b1);

        // Full-range run (N=0)
        run(0, 1'b0, 0, 256 + PL + 1, 1'b1);

        // Abort in cycle 5, then a new start is accepted
        run(8, 1'b0, 5, 10, 1'b0);
        run(4, 1'b0, 0, 4 + PL + 2, 1'b0);

        // Loop mode stopped by abort
        run(3, 1'b1, 20, 24, 1'b1);

        // start with abort in IDLE is ignored; abort alone in IDLE does nothing
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        idle(3);
        @(negedge clk);
        bus.abort = 1'b1;
        idle(2);

        // Asynchronous reset in the middle of DRAIN
        run(4, 1'b0, 0, 6, 1'b0);
        rst = 1'b0;
        #1;
        check_all_zero("rst_drain");
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        run(2, 1'b0, 0, 2 + PL + 1, 1'b0);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            n  = $urandom_range(1, 12);
            lp = 1'($urandom_range(0, 1));
            if (lp) begin
                ab   = $urandom_range(2, 30);
                kmax = ab + 3;
            end else begin
                ab   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n + PL + 1) : 0;
                kmax = n + PL + 2;
            end
            run(n, lp, ab, kmax, 1'b1);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
